// File: rtl/rf_write_buffer.sv
// Write-back staging FIFO in front of the 32x8 register file, with two-port read forwarding.
// Optional write coalescing into a queued entry is enabled by defining RF_WB_COALESCE_EN.
module rf_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [AW-1:0]          wr_addr,
  input  logic [DW-1:0]          wr_data,
  input  logic                   drain_en,
  output logic                   rf_mode,
  output logic [AW-1:0]          rf_write_add,
  output logic [DW-1:0]          rf_write_inp,
  input  logic [AW-1:0]          lk_addr_1,
  input  logic [AW-1:0]          lk_addr_2,
  output logic                   lk_hit_1,
  output logic                   lk_hit_2,
  output logic [DW-1:0]          lk_data_1,
  output logic [DW-1:0]          lk_data_2,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [AW-1:0]    entry_addr [DEPTH];
  logic [DW-1:0]    entry_data [DEPTH];
  logic [DEPTH-1:0] entry_valid;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             rf_valid;
  logic             not_full;
  logic             do_pop;
  logic             do_alloc;

  assign not_full = (count != FULL);
  assign do_pop   = drain_en && (count != '0);

`ifdef RF_WB_COALESCE_EN
  logic          coal_hit;
  logic [PW-1:0] coal_idx;

  // Youngest matching entry wins; the head is skipped when it leaves this same edge.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[head + PW'(i)] && (entry_addr[head + PW'(i)] == wr_addr) &&
          !(do_pop && (i == 0))) begin
        coal_hit = 1'b1;
        coal_idx = head + PW'(i);
      end
    end
  end

  assign wr_ready = not_full || coal_hit;
  assign do_alloc = wr_valid && !coal_hit && not_full;
`else
  assign wr_ready = not_full;
  assign do_alloc = wr_valid && not_full;
`endif

  // Entry payloads carry no reset; validity is tracked separately in entry_valid.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      entry_addr[tail] <= wr_addr;
      entry_data[tail] <= wr_data;
    end
`ifdef RF_WB_COALESCE_EN
    if (wr_valid && coal_hit) begin
      entry_data[coal_idx] <= wr_data;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      entry_valid  <= '0;
      rf_mode      <= 1'b1;
      rf_valid     <= 1'b0;
      rf_write_add <= '0;
      rf_write_inp <= '0;
    end else begin
      if (do_pop) begin
        rf_write_add      <= entry_addr[head];
        rf_write_inp      <= entry_data[head];
        rf_mode           <= 1'b0;
        rf_valid          <= 1'b1;
        entry_valid[head] <= 1'b0;
        head              <= head + 1'b1;
      end else begin
        rf_mode  <= 1'b1;
        rf_valid <= 1'b0;
      end
      if (do_alloc) begin
        entry_valid[tail] <= 1'b1;
        tail              <= tail + 1'b1;
      end
      count <= count + (PW+1)'(do_alloc) - (PW+1)'(do_pop);
    end
  end

  // Scan oldest to youngest so later matches override; the in-flight write has lowest priority.
  function automatic logic [DW:0] lookup(input logic [AW-1:0] a);
    logic [DW:0] r;
    r = '0;
    if (rf_valid && (rf_write_add == a)) begin
      r = {1'b1, rf_write_inp};
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[head + PW'(i)] && (entry_addr[head + PW'(i)] == a)) begin
        r = {1'b1, entry_data[head + PW'(i)]};
      end
    end
    return r;
  endfunction

  always_comb begin
    {lk_hit_1, lk_data_1} = lookup(lk_addr_1);
    {lk_hit_2, lk_data_2} = lookup(lk_addr_2);
  end

endmodule

// File: tb/tb_rf_write_buffer.sv
// Directed, table-driven bench for rf_write_buffer plus hand-written multi-cycle sequences.
module tb_rf_write_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       drain_en = 1'b0;
  logic       rf_mode;
  logic [4:0] rf_write_add;
  logic [7:0] rf_write_inp;
  logic [4:0] lk_addr_1 = '0;
  logic [4:0] lk_addr_2 = '0;
  logic       lk_hit_1;
  logic       lk_hit_2;
  logic [7:0] lk_data_1;
  logic [7:0] lk_data_2;
  logic [2:0] count;

  int total = 0;
  int bad = 0;

`ifdef RF_WB_COALESCE_EN
  localparam int C_DUP   = 1;
  localparam int D_FIRST = 'hBB;
  localparam int EXP3    = 'hEE;
  localparam int FULL_RDY = 1;
`else
  localparam int C_DUP   = 2;
  localparam int D_FIRST = 'hAA;
  localparam int EXP3    = 'h12;
  localparam int FULL_RDY = 0;
`endif

  typedef struct {
    logic       wv;
    logic [4:0] wa;
    logic [7:0] wd;
    logic       de;
    logic [4:0] l1;
    logic [4:0] l2;
    logic       e_ready;
    logic [2:0] e_count;
    logic       e_mode;
    logic [4:0] e_add;
    logic [7:0] e_inp;
    logic       e_h1;
    logic [7:0] e_d1;
    logic       e_h2;
    logic [7:0] e_d2;
  } vec_t;

  vec_t tbl [20];

  rf_write_buffer #(.DEPTH(4), .AW(5), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .drain_en(drain_en), .rf_mode(rf_mode), .rf_write_add(rf_write_add), .rf_write_inp(rf_write_inp),
    .lk_addr_1(lk_addr_1), .lk_addr_2(lk_addr_2), .lk_hit_1(lk_hit_1), .lk_hit_2(lk_hit_2),
    .lk_data_1(lk_data_1), .lk_data_2(lk_data_2), .count(count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int wv, int wa, int wd, int de, int l1, int l2, int er, int ec,
                              int em, int ea, int ei, int h1, int d1, int h2, int d2);
    vec_t v;
    v.wv = 1'(wv);      v.wa = 5'(wa);      v.wd = 8'(wd);      v.de = 1'(de);
    v.l1 = 5'(l1);      v.l2 = 5'(l2);      v.e_ready = 1'(er); v.e_count = 3'(ec);
    v.e_mode = 1'(em);  v.e_add = 5'(ea);   v.e_inp = 8'(ei);
    v.e_h1 = 1'(h1);    v.e_d1 = 8'(d1);    v.e_h2 = 1'(h2);    v.e_d2 = 8'(d2);
    return v;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic applyStimulus(input vec_t v);
    wr_valid  = v.wv;
    wr_addr   = v.wa;
    wr_data   = v.wd;
    drain_en  = v.de;
    lk_addr_1 = v.l1;
    lk_addr_2 = v.l2;
    #1;
  endtask

  task automatic checkRow(input int r, input vec_t v);
    checkOutput($sformatf("r%0d wr_ready", r), int'(wr_ready), int'(v.e_ready));
    checkOutput($sformatf("r%0d count", r), int'(count), int'(v.e_count));
    checkOutput($sformatf("r%0d rf_mode", r), int'(rf_mode), int'(v.e_mode));
    checkOutput($sformatf("r%0d rf_write_add", r), int'(rf_write_add), int'(v.e_add));
    checkOutput($sformatf("r%0d rf_write_inp", r), int'(rf_write_inp), int'(v.e_inp));
    checkOutput($sformatf("r%0d lk_hit_1", r), int'(lk_hit_1), int'(v.e_h1));
    checkOutput($sformatf("r%0d lk_data_1", r), int'(lk_data_1), int'(v.e_d1));
    checkOutput($sformatf("r%0d lk_hit_2", r), int'(lk_hit_2), int'(v.e_h2));
    checkOutput($sformatf("r%0d lk_data_2", r), int'(lk_data_2), int'(v.e_d2));
  endtask

  task automatic pushOne(input int a, input int d);
    wr_valid = 1'b1;
    wr_addr  = 5'(a);
    wr_data  = 8'(d);
    drain_en = 1'b0;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tbl[0]  = mk(1, 11, 'h5A, 0, 11, 0,  1, 0, 1, 0, 0,      0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 1, 11, 3,      1, 1, 1, 0, 0,      1, 'h5A, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 11, 11,     1, 0, 0, 11, 'h5A,  1, 'h5A, 1, 'h5A);
    tbl[3]  = mk(0, 0, 0, 0, 11, 0,      1, 0, 1, 11, 'h5A,  0, 0, 0, 0);
    tbl[4]  = mk(1, 1, 'h10, 0, 1, 0,    1, 0, 1, 11, 'h5A,  0, 0, 0, 0);
    tbl[5]  = mk(1, 2, 'h11, 0, 1, 2,    1, 1, 1, 11, 'h5A,  1, 'h10, 0, 0);
    tbl[6]  = mk(1, 3, 'h12, 0, 2, 1,    1, 2, 1, 11, 'h5A,  1, 'h11, 1, 'h10);
    tbl[7]  = mk(1, 4, 'h13, 0, 3, 4,    1, 3, 1, 11, 'h5A,  1, 'h12, 0, 0);
    tbl[8]  = mk(1, 5, 'h14, 0, 4, 5,    0, 4, 1, 11, 'h5A,  1, 'h13, 0, 0);
    tbl[9]  = mk(0, 0, 0, 1, 5, 1,       0, 4, 1, 11, 'h5A,  0, 0, 1, 'h10);
    tbl[10] = mk(0, 0, 0, 1, 1, 2,       1, 3, 0, 1, 'h10,   1, 'h10, 1, 'h11);
    tbl[11] = mk(0, 0, 0, 1, 2, 1,       1, 2, 0, 2, 'h11,   1, 'h11, 0, 0);
    tbl[12] = mk(0, 0, 0, 1, 4, 3,       1, 1, 0, 3, 'h12,   1, 'h13, 1, 'h12);
    tbl[13] = mk(0, 0, 0, 1, 4, 0,       1, 0, 0, 4, 'h13,   1, 'h13, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 4, 0,       1, 0, 1, 4, 'h13,   0, 0, 0, 0);
    tbl[15] = mk(1, 7, 'hAA, 0, 7, 9,    1, 0, 1, 4, 'h13,   0, 0, 0, 0);
    tbl[16] = mk(1, 7, 'hBB, 0, 7, 9,    1, 1, 1, 4, 'h13,   1, 'hAA, 0, 0);
    tbl[17] = mk(0, 0, 0, 0, 7, 9,       1, C_DUP, 1, 4, 'h13,     1, 'hBB, 0, 0);
    tbl[18] = mk(0, 0, 0, 1, 7, 9,       1, C_DUP, 1, 4, 'h13,     1, 'hBB, 0, 0);
    tbl[19] = mk(0, 0, 0, 1, 7, 9,       1, C_DUP - 1, 0, 7, D_FIRST, 1, 'hBB, 0, 0);

    // Reset values while rst is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    lk_addr_1 = 5'd11;
    #1;
    checkOutput("reset wr_ready", int'(wr_ready), 1);
    checkOutput("reset count", int'(count), 0);
    checkOutput("reset rf_mode", int'(rf_mode), 1);
    checkOutput("reset rf_write_add", int'(rf_write_add), 0);
    checkOutput("reset rf_write_inp", int'(rf_write_inp), 0);
    checkOutput("reset lk_hit_1", int'(lk_hit_1), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 20; r++) begin
      applyStimulus(tbl[r]);
      checkRow(r, tbl[r]);
      @(negedge clk);
    end

    // Flush whatever the duplicate-address rows left behind.
    wr_valid = 1'b0;
    drain_en = 1'b1;
    repeat (3) @(negedge clk);
    drain_en = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("flush count", int'(count), 0);
    checkOutput("flush rf_mode", int'(rf_mode), 1);

    // Full queue with simultaneous push and drain: one pop, no push.
    for (int i = 0; i < 4; i++) pushOne(20 + i, 'h30 + i);
    #1;
    checkOutput("full count", int'(count), 4);
    checkOutput("full wr_ready", int'(wr_ready), 0);
    wr_valid = 1'b1;
    wr_addr  = 5'd24;
    wr_data  = 8'h34;
    drain_en = 1'b1;
    #1;
    checkOutput("full+drain wr_ready", int'(wr_ready), 0);
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    checkOutput("after pop count", int'(count), 3);
    checkOutput("after pop wr_ready", int'(wr_ready), 1);
    checkOutput("after pop rf_mode", int'(rf_mode), 0);
    checkOutput("after pop add", int'(rf_write_add), 20);
    checkOutput("after pop inp", int'(rf_write_inp), 'h30);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("order%0d add", k), int'(rf_write_add), 20 + k);
      checkOutput($sformatf("order%0d inp", k), int'(rf_write_inp), 'h30 + k);
      checkOutput($sformatf("order%0d rf_mode", k), int'(rf_mode), 0);
    end
    checkOutput("full drained count", int'(count), 0);
    drain_en = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of a drain.
    pushOne(5, 'h55);
    pushOne(6, 'h66);
    pushOne(8, 'h88);
    drain_en  = 1'b1;
    lk_addr_1 = 5'd6;
    @(negedge clk);
    #1;
    checkOutput("pre-rst rf_mode", int'(rf_mode), 0);
    checkOutput("pre-rst count", int'(count), 2);
    checkOutput("pre-rst lk_hit_1", int'(lk_hit_1), 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async rst rf_mode", int'(rf_mode), 1);
    checkOutput("async rst count", int'(count), 0);
    checkOutput("async rst rf_write_add", int'(rf_write_add), 0);
    checkOutput("async rst rf_write_inp", int'(rf_write_inp), 0);
    checkOutput("async rst wr_ready", int'(wr_ready), 1);
    checkOutput("async rst lk_hit_1", int'(lk_hit_1), 0);
    drain_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("post-rst count", int'(count), 0);
    checkOutput("post-rst rf_mode", int'(rf_mode), 1);

    // Write to an address already queued while the queue is full.
    for (int i = 0; i < 4; i++) pushOne(1 + i, 'h10 + i);
    wr_valid  = 1'b1;
    wr_addr   = 5'd3;
    wr_data   = 8'hEE;
    drain_en  = 1'b0;
    lk_addr_1 = 5'd3;
    #1;
    checkOutput("full same-addr wr_ready", int'(wr_ready), FULL_RDY);
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    checkOutput("full same-addr count", int'(count), 4);
    checkOutput("full same-addr lk_data_1", int'(lk_data_1), EXP3);
    drain_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("same-addr drain%0d add", k), int'(rf_write_add), 1 + k);
      checkOutput($sformatf("same-addr drain%0d inp", k), int'(rf_write_inp),
                  (k == 2) ? EXP3 : ('h10 + k));
    end
    checkOutput("same-addr final count", int'(count), 0);
    drain_en = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
